// File: rtl/p_deser.sv
// rtl/p_deser.sv - accepts one word per valid/ready handshake and assembles NB_OUTS words into a bundle
module p_deser #(
  parameter int BUS_WIDTH = 4,
  parameter int NB_OUTS   = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [BUS_WIDTH-1:0]           in_bus,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           flush,
  output logic [BUS_WIDTH-1:0]           out_buses [NB_OUTS-1:0],
  output logic [$clog2(NB_OUTS+1)-1:0]   out_count,
  output logic                           out_valid,
  input  logic                           out_ready
);
  localparam int IW = $clog2(NB_OUTS);
  localparam int CW = $clog2(NB_OUTS+1);

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t               r_state;
  logic [IW-1:0]        r_idx;
  logic [BUS_WIDTH-1:0] r_bus [NB_OUTS-1:0];
  logic [CW-1:0]        r_count;
  logic                 r_valid;
  logic                 w_last;

  assign w_last    = (r_idx == IW'(NB_OUTS-1));
  assign in_ready  = (r_state == S_FILL);
  assign out_buses = r_bus;
  assign out_count = r_count;
  assign out_valid = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_idx   <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < NB_OUTS; i++) r_bus[i] <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (in_valid) begin
            r_bus[r_idx] <= in_bus;
            r_count      <= r_count + CW'(1);
            r_idx        <= w_last ? '0 : r_idx + IW'(1);
          end
          // flush qualifies on the count including a same-cycle accept
          if ((in_valid && w_last) || (flush && (in_valid || r_count != '0))) begin
            r_state <= S_FULL;
            r_valid <= 1'b1;
            r_idx   <= '0;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            r_state <= S_FILL;
            r_valid <= 1'b0;
            r_count <= '0;
            r_idx   <= '0;
            for (int i = 0; i < NB_OUTS; i++) r_bus[i] <= '0;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_p_deser.sv
// tb/tb_p_deser.sv - table-driven and scoreboard bench for p_deser
module tb_p_deser;
  localparam int W = 4;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_bus;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] out_buses [N-1:0];
  logic [1:0]   out_count;
  logic         out_valid;
  logic         out_ready;

  p_deser #(.BUS_WIDTH(W), .NB_OUTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_buses(out_buses),
    .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [3:0] d; logic fl; logic ordy;
    logic er; logic ev; logic [1:0] ec; logic [3:0] e0; logic [3:0] e1; logic [3:0] e2;
  } vec_t;

  typedef struct { logic [1:0] cnt; logic [3:0] b0; logic [3:0] b1; logic [3:0] b2; } bundle_t;

  vec_t    vecs[$];
  bundle_t sb_q[$];
  logic [3:0] part [N];
  int pcnt;
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [15:0] snap();
    return {in_ready, out_valid, out_count, out_buses[0], out_buses[1], out_buses[2]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_reset();
    sb_q.delete();
    pcnt = 0;
    for (int i = 0; i < N; i++) part[i] = 4'h0;
  endtask

  task automatic sb_push();
    sb_q.push_back('{2'(pcnt), part[0], part[1], part[2]});
    pcnt = 0;
    for (int i = 0; i < N; i++) part[i] = 4'h0;
  endtask

  // Drives one cycle; the reference bundle model updates from the pre-edge handshakes.
  task automatic step(input logic v, input logic [3:0] d, input logic fl, input logic ordy);
    @(negedge clk);
    in_valid = v; in_bus = d; flush = fl; out_ready = ordy;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_pop: bundle handshake with count %0d but no bundle expected", out_count);
      end else begin
        bundle_t b;
        b = sb_q.pop_front();
        check("sb_bundle", {4'h0, out_count, out_buses[0], out_buses[1], out_buses[2]} & 16'h3fff,
              {4'h0, b.cnt, b.b0, b.b1, b.b2} & 16'h3fff);
      end
    end
    if (in_valid && in_ready) begin
      part[pcnt] = d;
      pcnt++;
    end
    if (in_ready && (pcnt == N || (fl && pcnt > 0))) sb_push();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic v, input logic [3:0] d, input logic fl, input logic ordy,
                              input logic er, input logic ev, input logic [1:0] ec,
                              input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2);
    vecs.push_back('{v, d, fl, ordy, er, ev, ec, e0, e1, e2});
  endfunction

  initial begin
    in_valid = 0; in_bus = 0; flush = 0; out_ready = 0;
    sb_reset();
    #12;
    check("reset_async", snap(), {1'b1, 1'b0, 2'd0, 12'h000});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release", snap(), {1'b1, 1'b0, 2'd0, 12'h000});

    // full bundle
    add(1,4'hD,0,1, 1,0,2'd1, 4'hD,4'h0,4'h0);
    add(1,4'hB,0,1, 1,0,2'd2, 4'hD,4'hB,4'h0);
    add(1,4'hF,0,1, 0,1,2'd3, 4'hD,4'hB,4'hF);
    add(0,4'h0,0,1, 1,0,2'd0, 4'h0,4'h0,4'h0);
    // back-pressure
    add(1,4'hD,0,1, 1,0,2'd1, 4'hD,4'h0,4'h0);
    add(1,4'hB,0,1, 1,0,2'd2, 4'hD,4'hB,4'h0);
    add(1,4'hF,0,0, 0,1,2'd3, 4'hD,4'hB,4'hF);
    for (int i = 0; i < 5; i++) add(1,4'h1,0,0, 0,1,2'd3, 4'hD,4'hB,4'hF);
    add(1,4'h1,0,1, 1,0,2'd0, 4'h0,4'h0,4'h0);
    add(1,4'h1,0,1, 1,0,2'd1, 4'h1,4'h0,4'h0);
    add(0,4'h0,1,0, 0,1,2'd1, 4'h1,4'h0,4'h0);
    add(0,4'h0,0,1, 1,0,2'd0, 4'h0,4'h0,4'h0);
    // gapped input
    add(1,4'h3,0,1, 1,0,2'd1, 4'h3,4'h0,4'h0);
    add(0,4'h0,0,1, 1,0,2'd1, 4'h3,4'h0,4'h0);
    add(0,4'h0,0,1, 1,0,2'd1, 4'h3,4'h0,4'h0);
    add(1,4'h5,0,1, 1,0,2'd2, 4'h3,4'h5,4'h0);
    add(0,4'h0,0,1, 1,0,2'd2, 4'h3,4'h5,4'h0);
    add(1,4'h9,0,1, 0,1,2'd3, 4'h3,4'h5,4'h9);
    add(0,4'h0,0,1, 1,0,2'd0, 4'h0,4'h0,4'h0);
    // flush cases
    add(1,4'hA,0,0, 1,0,2'd1, 4'hA,4'h0,4'h0);
    add(1,4'h6,0,0, 1,0,2'd2, 4'hA,4'h6,4'h0);
    add(0,4'h0,1,0, 0,1,2'd2, 4'hA,4'h6,4'h0);
    add(0,4'h0,1,1, 1,0,2'd0, 4'h0,4'h0,4'h0);
    add(0,4'h0,1,0, 1,0,2'd0, 4'h0,4'h0,4'h0);
    add(1,4'hE,1,0, 0,1,2'd1, 4'hE,4'h0,4'h0);
    add(0,4'h0,0,1, 1,0,2'd0, 4'h0,4'h0,4'h0);
    add(1,4'h1,0,0, 1,0,2'd1, 4'h1,4'h0,4'h0);
    add(1,4'h2,0,0, 1,0,2'd2, 4'h1,4'h2,4'h0);
    add(1,4'h4,1,0, 0,1,2'd3, 4'h1,4'h2,4'h4);
    add(0,4'h0,0,1, 1,0,2'd0, 4'h0,4'h0,4'h0);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].fl, vecs[i].ordy);
      check($sformatf("vec%0d", i), snap(),
            {vecs[i].er, vecs[i].ev, vecs[i].ec, vecs[i].e0, vecs[i].e1, vecs[i].e2});
    end

    // reset while filling
    step(1, 4'hC, 0, 0);
    check("rst_fill_pre", snap(), {1'b1, 1'b0, 2'd1, 12'hC00});
    #2 rst_n = 1'b0; in_valid = 0; flush = 0;
    #1 check("rst_fill_async", snap(), {1'b1, 1'b0, 2'd0, 12'h000});
    sb_reset();
    @(negedge clk) rst_n = 1'b1;
    step(1, 4'h7, 0, 0);
    step(1, 4'h8, 0, 0);
    step(1, 4'h2, 0, 0);
    check("rst_fill_bundle", snap(), {1'b0, 1'b1, 2'd3, 12'h782});
    step(0, 4'h0, 0, 1);
    check("rst_fill_drain", snap(), {1'b1, 1'b0, 2'd0, 12'h000});

    // reset while holding a full bundle
    step(1, 4'h5, 0, 0);
    step(1, 4'h6, 0, 0);
    step(1, 4'h7, 0, 0);
    check("rst_full_pre", snap(), {1'b0, 1'b1, 2'd3, 12'h567});
    #2 rst_n = 1'b0; in_valid = 0; flush = 0;
    #1 check("rst_full_async", snap(), {1'b1, 1'b0, 2'd0, 12'h000});
    sb_reset();
    @(negedge clk) rst_n = 1'b1;
    step(1, 4'hF, 0, 0);
    check("rst_full_slot0", snap(), {1'b1, 1'b0, 2'd1, 12'hF00});
    step(0, 4'h0, 1, 0);
    check("rst_full_flush", snap(), {1'b0, 1'b1, 2'd1, 12'hF00});
    step(0, 4'h0, 0, 1);
    check("sb_drained", 16'(sb_q.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
